// File: rtl/seq_alu_if.sv
// Request/response channel of the sequential ALU: a valid/ready operation
// request (opcode, A, B) and a valid/ready result (G, ZCNV flags, illegal).
interface seq_alu_if #(
  parameter int XLEN = 32
) ();

  logic            in_valid;
  logic            in_ready;
  logic [3:0]      G_sel;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] G;
  logic [3:0]      ZCNVFlags;
  logic            illegal;

  modport master (
    output in_valid, G_sel, A, B, out_ready,
    input  in_ready, out_valid, G, ZCNVFlags, illegal
  );

  modport slave (
    input  in_valid, G_sel, A, B, out_ready,
    output in_ready, out_valid, G, ZCNVFlags, illegal
  );

endinterface

// File: rtl/seq_alu.sv
// Handshaked integer ALU with an iterative shifter moving SHIFT_STEP bits per
// cycle; results and ZCNV flags are registered and held until consumed.
module seq_alu #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  seq_alu_if.slave  bus
);

  localparam int SHW = $clog2(XLEN);
  // One extra bit so SHIFT_STEP == XLEN is still representable in compares.
  localparam int CW  = SHW + 1;
  localparam logic [CW-1:0] STEP = CW'(SHIFT_STEP);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_SLL  = 4'b0010,
    OP_SLT  = 4'b0100,
    OP_SLTU = 4'b0110,
    OP_XOR  = 4'b1000,
    OP_SRL  = 4'b1010,
    OP_SRA  = 4'b1011,
    OP_OR   = 4'b1100,
    OP_AND  = 4'b1110
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;
  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shift_e;

  typedef struct packed {
    logic [XLEN-1:0] g;
    logic [3:0]      flags;
    logic            illegal;
  } result_t;

  state_e          state;
  logic [XLEN-1:0] work;
  logic [CW-1:0]   remaining;
  shift_e          shift_kind;
  logic            sign;
  result_t         res_q;

  result_t         res_c;
  logic            is_shift;
  shift_e          shift_kind_c;
  logic [SHW-1:0]  shamt;
  logic [XLEN:0]   sum;
  logic [XLEN-1:0] diff;
  logic            c_flag;
  logic            v_flag;

  logic [CW-1:0]   amt;
  logic [CW-1:0]   rem_next;
  logic [XLEN-1:0] shifted;

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.G         = res_q.g;
  assign bus.ZCNVFlags = res_q.flags;
  assign bus.illegal   = res_q.illegal;

  assign shamt = bus.B[SHW-1:0];

  // Single-cycle datapath; also yields the pass-through result for shamt=0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    res_c        = '0;
    c_flag       = 1'b0;
    v_flag       = 1'b0;
    is_shift     = 1'b0;
    shift_kind_c = SH_LL;
    sum          = {1'b0, bus.A} + {1'b0, bus.B};
    diff         = bus.A - bus.B;
    case (bus.G_sel)
      OP_ADD: begin
        res_c.g = sum[XLEN-1:0];
        c_flag  = sum[XLEN];
        v_flag  = (bus.A[XLEN-1] == bus.B[XLEN-1]) && (sum[XLEN-1] != bus.A[XLEN-1]);
      end
      OP_SUB: begin
        res_c.g = diff;
        c_flag  = (bus.A >= bus.B);
        v_flag  = (bus.A[XLEN-1] != bus.B[XLEN-1]) && (diff[XLEN-1] != bus.A[XLEN-1]);
      end
      OP_SLT:  res_c.g = {{(XLEN-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      OP_SLTU: res_c.g = {{(XLEN-1){1'b0}}, (bus.A < bus.B)};
      OP_XOR:  res_c.g = bus.A ^ bus.B;
      OP_OR:   res_c.g = bus.A | bus.B;
      OP_AND:  res_c.g = bus.A & bus.B;
      OP_SLL: begin
        res_c.g  = bus.A;
        is_shift = 1'b1;
      end
      OP_SRL: begin
        res_c.g      = bus.A;
        is_shift     = 1'b1;
        shift_kind_c = SH_RL;
      end
      OP_SRA: begin
        res_c.g      = bus.A;
        is_shift     = 1'b1;
        shift_kind_c = SH_RA;
      end
      default: res_c.illegal = 1'b1;
    endcase
    res_c.flags = {(res_c.g == '0), c_flag, res_c.g[XLEN-1], v_flag};
  end

  // One iteration of the shifter: at most SHIFT_STEP positions per cycle.
  always_comb begin
    amt      = (remaining < STEP) ? remaining : STEP;
    rem_next = remaining - amt;
    case (shift_kind)
      SH_LL:   shifted = work << amt;
      SH_RL:   shifted = work >> amt;
      default: shifted = (work >> amt) | (sign ? ~({XLEN{1'b1}} >> amt) : '0);
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, and every
  // register (including the shifter working state) is cleared by the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      work       <= '0;
      remaining  <= '0;
      shift_kind <= SH_LL;
      sign       <= 1'b0;
      res_q      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            if (is_shift && (shamt != '0)) begin
              work       <= bus.A;
              remaining  <= CW'(shamt);
              shift_kind <= shift_kind_c;
              sign       <= bus.A[XLEN-1];
              state      <= S_SHIFT;
            end else begin
              res_q <= res_c;
              state <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          work      <= shifted;
          remaining <= rem_next;
          if (rem_next == '0) begin
            res_q.g       <= shifted;
            res_q.flags   <= {(shifted == '0), 1'b0, shifted[XLEN-1], 1'b0};
            res_q.illegal <= 1'b0;
            state         <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (XLEN=32, SHIFT_STEP=4): reset, flags, compares,
// iterative shifts, backpressure, illegal opcode and back-to-back random ops.
module tb_seq_alu;

  localparam int XLEN = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  seq_alu_if #(.XLEN(XLEN)) bus ();

  seq_alu #(.XLEN(XLEN), .SHIFT_STEP(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent reference: 64-bit signed arithmetic for overflow detection.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] g, output logic [3:0] f);
    logic  c;
    logic  v;
    longint sa;
    longint sb;
    longint r;
    logic [32:0] w;
    c  = 1'b0;
    v  = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    g  = '0;
    case (op)
      4'b0000: begin
        w = {1'b0, a} + {1'b0, b};
        g = w[31:0];
        c = w[32];
        r = sa + sb;
        v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      4'b0001: begin
        g = a - b;
        c = (a >= b);
        r = sa - sb;
        v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      4'b0010: g = a << b[4:0];
      4'b0100: g = (sa < sb) ? 32'd1 : 32'd0;
      4'b0110: g = (a < b) ? 32'd1 : 32'd0;
      4'b1000: g = a ^ b;
      4'b1010: g = a >> b[4:0];
      4'b1011: g = $signed(a) >>> b[4:0];
      4'b1100: g = a | b;
      4'b1110: g = a & b;
      default: g = '0;
    endcase
    f = {(g == 32'd0), c, g[31], v};
  endtask

  // Called #1 after a rising edge with the DUT idle; returns cycles to out_valid.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    bus.G_sel    = op;
    bus.A        = a;
    bus.B        = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic complete(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, ".in_ready_after"}, bus.in_ready, 1'b1);
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp_g, input logic [3:0] exp_f,
                     input logic exp_ill, input int exp_lat);
    int lat;
    issue(op, a, b, lat);
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".G"}, bus.G, exp_g);
    check({tag, ".flags"}, bus.ZCNVFlags, exp_f);
    check({tag, ".illegal"}, bus.illegal, exp_ill);
    complete(tag);
  endtask

  initial begin
    int          lat;
    int          acc;
    int          prev_acc;
    logic        prev_shift;
    logic [3:0]  ops [10];
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] mg;
    logic [3:0]  mf;
    int          exp_lat;

    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0110,
            4'b1000, 4'b1010, 4'b1011, 4'b1100, 4'b1110};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.G_sel     = '0;
    bus.A         = '0;
    bus.B         = '0;

    #12;
    check("reset.in_ready", bus.in_ready, 1'b1);
    check("reset.out_valid", bus.out_valid, 1'b0);
    check("reset.G", bus.G, 32'd0);
    check("reset.flags", bus.ZCNVFlags, 4'd0);
    check("reset.illegal", bus.illegal, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run("add5_7", 4'b0000, 32'd5, 32'd7, 32'd12, 4'b0000, 1'b0, 1);

    // Abandon an SLL by 31 partway through its iterations.
    bus.G_sel = 4'b0010; bus.A = 32'd1; bus.B = 32'd31; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midreset.out_valid", bus.out_valid, 1'b0);
    check("midreset.in_ready", bus.in_ready, 1'b1);
    check("midreset.G", bus.G, 32'd0);
    check("midreset.flags", bus.ZCNVFlags, 4'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run("add5_7_post_reset", 4'b0000, 32'd5, 32'd7, 32'd12, 4'b0000, 1'b0, 1);

    run("add_carry", 4'b0000, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 4'b1100, 1'b0, 1);
    run("add_ovf", 4'b0000, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b0011, 1'b0, 1);
    run("sub_borrow", 4'b0001, 32'd3, 32'd5, 32'hFFFF_FFFE, 4'b0010, 1'b0, 1);
    run("slt_neg", 4'b0100, 32'hFFFF_FFFF, 32'd1, 32'd1, 4'b0000, 1'b0, 1);
    run("sltu_neg", 4'b0110, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b1000, 1'b0, 1);
    run("slt_eq", 4'b0100, 32'd5, 32'd5, 32'd0, 4'b1000, 1'b0, 1);

    run("sra9", 4'b1011, 32'h8000_0000, 32'd9, 32'hFFC0_0000, 4'b0010, 1'b0, 4);
    run("srl9", 4'b1010, 32'h8000_0000, 32'd9, 32'h0040_0000, 4'b0000, 1'b0, 4);
    run("sll0", 4'b0010, 32'd1, 32'd0, 32'd1, 4'b0000, 1'b0, 1);
    run("sll31", 4'b0010, 32'd1, 32'd31, 32'h8000_0000, 4'b0010, 1'b0, 9);
    run("sra_pos", 4'b1011, 32'h4000_0000, 32'h0000_0104, 32'h0400_0000, 4'b0000, 1'b0, 2);

    // Backpressure: result held while operands and opcode wander.
    issue(4'b1000, 32'hF0F0_F0F0, 32'hFFFF_0000, lat);
    check("bp.latency", lat, 1);
    for (int i = 0; i < 10; i++) begin
      bus.A     = $urandom;
      bus.B     = $urandom;
      bus.G_sel = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
      check("bp.G", bus.G, 32'h0F0F_F0F0);
      check("bp.in_ready", bus.in_ready, 1'b0);
      check("bp.out_valid", bus.out_valid, 1'b1);
    end
    check("bp.flags", bus.ZCNVFlags, 4'b0000);
    complete("bp");

    run("illegal", 4'b0011, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 4'b1000, 1'b1, 1);

    // Back-to-back random ops with the consumer always ready.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    prev_acc      = 0;
    prev_shift    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      op = ops[$urandom_range(0, 9)];
      a  = $urandom;
      b  = $urandom;
      model(op, a, b, mg, mf);
      exp_lat = ((op == 4'b0010) || (op == 4'b1010) || (op == 4'b1011))
                ? 1 + ((int'(b[4:0]) + 3) / 4) : 1;
      check("b2b.in_ready", bus.in_ready, 1'b1);
      bus.G_sel = op;
      bus.A     = a;
      bus.B     = b;
      @(posedge clk); #1;
      acc = cyc;
      if (!prev_shift) check("b2b.spacing", acc - prev_acc, 2);
      lat = 1;
      while (!bus.out_valid && lat < 100) begin
        @(posedge clk); #1;
        lat++;
      end
      check("b2b.latency", lat, exp_lat);
      check("b2b.G", bus.G, mg);
      check("b2b.flags", bus.ZCNVFlags, mf);
      check("b2b.illegal", bus.illegal, 1'b0);
      prev_acc   = acc;
      prev_shift = (exp_lat != 1);
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    check("final.in_ready", bus.in_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
